// File: rtl/w_handler_param.sv
// w_handler_param: write-clock-domain pointer handler for the async FIFO.
// Owns the binary and Gray write pointers, synchronizes the incoming Gray
// read pointer, and reports full, almost_full and the write-side fill level.
// Optional overflow tracking (sticky flag plus saturating drop counter) is
// built when the macro WH_OVERFLOW_EN is defined; otherwise both outputs are 0.
module w_handler_param #(
  parameter int ADDR_WIDTH    = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int OVF_CNT_WIDTH = 8
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic                     wr,
  input  logic [ADDR_WIDTH:0]      g_rptr_async,
  input  logic [ADDR_WIDTH:0]      afull_thresh,
  input  logic                     clr_ovf,
  output logic [ADDR_WIDTH-1:0]    waddr,
  output logic                     wen,
  output logic [ADDR_WIDTH:0]      g_wptr,
  output logic                     full,
  output logic                     almost_full,
  output logic [ADDR_WIDTH:0]      wlevel,
  output logic                     overflow,
  output logic [OVF_CNT_WIDTH-1:0] ovf_cnt
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] b_wptr;
  logic [PW-1:0] b_wptr_next;
  logic [PW-1:0] b_rptr_sync;
  logic [PW-1:0] rptr_sync_q [SYNC_STAGES];

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wen         = wr & ~full;
  assign waddr       = b_wptr[ADDR_WIDTH-1:0];
  assign b_wptr_next = b_wptr + PW'(wen);

  // Write pointer pair; Gray copy is registered from the next binary value so it never glitches
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      b_wptr <= '0;
      g_wptr <= '0;
    end else begin
      b_wptr <= b_wptr_next;
      g_wptr <= bin2gray(b_wptr_next);
    end
  end

  // Read-pointer synchronizer chain; only the Gray code crosses, so a single bit changes per step
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) rptr_sync_q[i] <= '0;
    end else begin
      rptr_sync_q[0] <= g_rptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) rptr_sync_q[i] <= rptr_sync_q[i-1];
    end
  end

  assign b_rptr_sync = gray2bin(rptr_sync_q[SYNC_STAGES-1]);

  // Stale read pointer can only lag, so the level can only over-report
  assign wlevel      = b_wptr - b_rptr_sync;
  assign full        = (b_wptr[PW-1] != b_rptr_sync[PW-1]) &&
                       (b_wptr[ADDR_WIDTH-1:0] == b_rptr_sync[ADDR_WIDTH-1:0]);
  assign almost_full = (wlevel >= afull_thresh);

`ifdef WH_OVERFLOW_EN
  logic ovf_evt;
  assign ovf_evt = wr & full;

  // Sticky flag and saturating counter; a drop on the clearing edge restarts the count at 1
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end else if (ovf_evt) begin
      overflow <= 1'b1;
      if (clr_ovf)
        ovf_cnt <= OVF_CNT_WIDTH'(1);
      else if (ovf_cnt != '1)
        ovf_cnt <= ovf_cnt + OVF_CNT_WIDTH'(1);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      ovf_cnt  <= '0;
    end
  end
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = clr_ovf;
  assign overflow       = 1'b0;
  assign ovf_cnt        = '0;
`endif

endmodule
